// File: rtl/alu_reg_op_executor_if.sv
// Decoder, register-file and accumulator/flag signals of the ALU-register executor.
// The slave modport is the executor's view; the master modport is the surrounding datapath.
interface alu_reg_op_executor_if;
    logic       enable_alu;
    logic       sel_b;
    logic       sel_c;
    logic       sel_d;
    logic       sel_e;
    logic       sel_h;
    logic       sel_l;
    logic       sel_a;
    logic [2:0] op;
    logic [2:0] rf_addr;
    logic       rf_re;
    logic [7:0] rf_rdata;
    logic [7:0] a_in;
    logic [7:0] f_in;
    logic [7:0] a_out;
    logic       a_we;
    logic [7:0] f_out;
    logic       f_we;
    logic       busy;
    logic       done;
    logic       err;

    modport slave (
        input  enable_alu, sel_b, sel_c, sel_d, sel_e, sel_h, sel_l, sel_a, op,
        input  rf_rdata, a_in, f_in,
        output rf_addr, rf_re, a_out, a_we, f_out, f_we, busy, done, err
    );

    modport master (
        output enable_alu, sel_b, sel_c, sel_d, sel_e, sel_h, sel_l, sel_a, op,
        output rf_rdata, a_in, f_in,
        input  rf_addr, rf_re, a_out, a_we, f_out, f_we, busy, done, err
    );
endinterface

// File: rtl/alu_reg_op_executor.sv
// Executes ADD/ADC/SUB/SBC/AND/XOR/OR/CP r: reads r from the register file,
// computes the result and Z80-style flags, and writes back A and F.
module alu_reg_op_executor #(
    parameter int READ_LATENCY = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    alu_reg_op_executor_if.slave        io_bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_EXEC,
        S_WB
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_CP  = 3'd7;

    // WAIT covers READ_LATENCY-1 cycles; the counter's final value ends it.
    localparam logic [1:0] WAIT_LAST = 2'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_op;
    logic [2:0] r_addr;
    logic [7:0] r_a;
    logic       r_cin;
    logic [1:0] r_waitCnt;
    logic       r_err;
    logic [7:0] r_aOut;
    logic [7:0] r_fOut;

    logic [6:0] w_sel;
    logic       w_selOk;
    logic [2:0] w_addr;
    logic [7:0] w_r;
    logic [7:0] w_res;
    logic [7:0] w_flags;
    logic [8:0] w_sum;
    logic       w_cin;
    logic       w_h;
    logic       w_pv;
    logic       w_n;
    logic       w_c;
    logic       w_f5;
    logic       w_f3;

    assign w_sel   = {io_bus.sel_a, io_bus.sel_l, io_bus.sel_h, io_bus.sel_e,
                      io_bus.sel_d, io_bus.sel_c, io_bus.sel_b};
    assign w_selOk = ($countones(w_sel) == 1);

    always_comb begin
        w_addr = 3'd0;
        if (io_bus.sel_c) w_addr = 3'd1;
        if (io_bus.sel_d) w_addr = 3'd2;
        if (io_bus.sel_e) w_addr = 3'd3;
        if (io_bus.sel_h) w_addr = 3'd4;
        if (io_bus.sel_l) w_addr = 3'd5;
        if (io_bus.sel_a) w_addr = 3'd7;
    end

    // Half carry/borrow is recovered from bit 4 as a ^ r ^ result for add and subtract alike.
    always_comb begin
        w_r   = io_bus.rf_rdata;
        w_cin = r_cin && ((r_op == OP_ADC) || (r_op == OP_SBC));
        w_sum = 9'd0;
        w_res = 8'd0;
        w_h   = 1'b0;
        w_pv  = 1'b0;
        w_n   = 1'b0;
        w_c   = 1'b0;
        case (r_op)
            OP_ADD, OP_ADC: begin
                w_sum = {1'b0, r_a} + {1'b0, w_r} + {8'd0, w_cin};
                w_res = w_sum[7:0];
                w_h   = r_a[4] ^ w_r[4] ^ w_res[4];
                w_c   = w_sum[8];
                w_pv  = (r_a[7] == w_r[7]) && (w_res[7] != r_a[7]);
            end
            OP_SUB, OP_SBC, OP_CP: begin
                w_sum = {1'b0, r_a} - {1'b0, w_r} - {8'd0, w_cin};
                w_res = w_sum[7:0];
                w_h   = r_a[4] ^ w_r[4] ^ w_res[4];
                w_c   = w_sum[8];
                w_pv  = (r_a[7] != w_r[7]) && (w_res[7] != r_a[7]);
                w_n   = 1'b1;
            end
            OP_AND: begin
                w_res = r_a & w_r;
                w_h   = 1'b1;
                w_pv  = ~^w_res;
            end
            OP_XOR: begin
                w_res = r_a ^ w_r;
                w_pv  = ~^w_res;
            end
            default: begin
                w_res = r_a | w_r;
                w_pv  = ~^w_res;
            end
        endcase
        w_f5    = (r_op == OP_CP) ? w_r[5] : w_res[5];
        w_f3    = (r_op == OP_CP) ? w_r[3] : w_res[3];
        w_flags = {w_res[7], (w_res == 8'd0), w_f5, w_h, w_f3, w_pv, w_n, w_c};
    end

    always_comb begin
        w_next         = r_state;
        io_bus.rf_re   = 1'b0;
        io_bus.rf_addr = 3'd0;
        io_bus.a_we    = 1'b0;
        io_bus.f_we    = 1'b0;
        io_bus.done    = 1'b0;
        io_bus.busy    = (r_state != S_IDLE);
        io_bus.err     = r_err;
        io_bus.a_out   = r_aOut;
        io_bus.f_out   = r_fOut;
        case (r_state)
            S_IDLE: begin
                if (io_bus.enable_alu && w_selOk) w_next = S_READ;
            end
            S_READ: begin
                io_bus.rf_re   = 1'b1;
                io_bus.rf_addr = r_addr;
                w_next         = (READ_LATENCY > 1) ? S_WAIT : S_EXEC;
            end
            S_WAIT: begin
                if (r_waitCnt == WAIT_LAST) w_next = S_EXEC;
            end
            S_EXEC: begin
                w_next = S_WB;
            end
            S_WB: begin
                io_bus.a_we = (r_op != OP_CP);
                io_bus.f_we = 1'b1;
                io_bus.done = 1'b1;
                w_next      = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // A is snapshotted at start; CP leaves the result register untouched since A is not written.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= 3'd0;
            r_addr    <= 3'd0;
            r_a       <= 8'd0;
            r_cin     <= 1'b0;
            r_waitCnt <= 2'd0;
            r_err     <= 1'b0;
            r_aOut    <= 8'd0;
            r_fOut    <= 8'd0;
        end else begin
            r_state <= w_next;
            r_err   <= 1'b0;
            if ((r_state == S_IDLE) && io_bus.enable_alu) begin
                if (w_selOk) begin
                    r_op   <= io_bus.op;
                    r_addr <= w_addr;
                    r_a    <= io_bus.a_in;
                    r_cin  <= io_bus.f_in[0];
                end else begin
                    r_err <= 1'b1;
                end
            end
            if (r_state == S_READ) r_waitCnt <= 2'd0;
            if (r_state == S_WAIT) r_waitCnt <= r_waitCnt + 2'd1;
            if (r_state == S_EXEC) begin
                if (r_op != OP_CP) r_aOut <= w_res;
                r_fOut <= w_flags;
            end
        end
    end
endmodule

// File: tb/tb_alu_reg_op_executor.sv
// Bench for alu_reg_op_executor: one instance at READ_LATENCY=1, one at 3,
// sharing a behavioural register file with latency-accurate read data.
module tb_alu_reg_op_executor;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_CP  = 3'd7;
    localparam logic [6:0] SB = 7'h01, SC = 7'h02, SD = 7'h04, SE = 7'h08;
    localparam logic [6:0] SH = 7'h10, SL = 7'h20, SA = 7'h40;

    typedef struct {
        logic [7:0] aOut;
        logic [7:0] fOut;
        logic       aWe;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] rfMem [8];
    exp_t       sbQ [$];

    alu_reg_op_executor_if ifc1 ();
    alu_reg_op_executor_if ifc3 ();

    alu_reg_op_executor #(.READ_LATENCY(1)) dut1 (.clock(clock), .reset(reset), .io_bus(ifc1.slave));
    alu_reg_op_executor #(.READ_LATENCY(3)) dut3 (.clock(clock), .reset(reset), .io_bus(ifc3.slave));

    always #5 clock = ~clock;

    // Read data is valid exactly READ_LATENCY cycles after rf_re, junk otherwise.
    logic       v1Pipe = 1'b0;
    logic [2:0] a1Pipe = 3'd0;
    logic [2:0] v3Pipe = 3'd0;
    logic [2:0] a3Pipe [3];

    always @(posedge clock) begin
        v1Pipe    <= ifc1.rf_re;
        a1Pipe    <= ifc1.rf_addr;
        v3Pipe    <= {v3Pipe[1:0], ifc3.rf_re};
        a3Pipe[0] <= ifc3.rf_addr;
        a3Pipe[1] <= a3Pipe[0];
        a3Pipe[2] <= a3Pipe[1];
    end

    assign ifc1.rf_rdata = v1Pipe ? rfMem[a1Pipe] : 8'hA5;
    assign ifc3.rf_rdata = v3Pipe[2] ? rfMem[a3Pipe[2]] : 8'hA5;

    task automatic setSel1(input logic [6:0] s);
        ifc1.sel_b = s[0]; ifc1.sel_c = s[1]; ifc1.sel_d = s[2]; ifc1.sel_e = s[3];
        ifc1.sel_h = s[4]; ifc1.sel_l = s[5]; ifc1.sel_a = s[6];
    endtask

    task automatic setSel3(input logic [6:0] s);
        ifc3.sel_b = s[0]; ifc3.sel_c = s[1]; ifc3.sel_d = s[2]; ifc3.sel_e = s[3];
        ifc3.sel_h = s[4]; ifc3.sel_l = s[5]; ifc3.sel_a = s[6];
    endtask

    // Starts one op on the latency-1 unit and checks read strobe, latency and write-back.
    task automatic applyStimulus(input string name, input logic [2:0] op, input logic [6:0] sels,
                                 input logic [2:0] expAddr, input logic [7:0] a, input logic [7:0] f,
                                 input logic [7:0] expA, input logic [7:0] expF, input logic expAWe,
                                 input bit pokeBusy);
        exp_t e;
        int   cyc;
        bit   seen;
        sbQ.push_back('{expA, expF, expAWe});
        @(negedge clock);
        ifc1.enable_alu = 1'b1; ifc1.op = op; setSel1(sels); ifc1.a_in = a; ifc1.f_in = f;
        @(negedge clock);
        ifc1.enable_alu = 1'b0; setSel1(7'd0); ifc1.a_in = ~a; ifc1.f_in = ~f;
        checks++;
        if (ifc1.rf_re !== 1'b1 || ifc1.busy !== 1'b1 || ifc1.rf_addr !== expAddr) begin
            failures++;
            $display("[TB] FAIL %s read: rf_re=%b busy=%b rf_addr=%0d, required 1 1 %0d",
                     name, ifc1.rf_re, ifc1.busy, ifc1.rf_addr, expAddr);
        end
        cyc  = 1;
        seen = 0;
        while (!seen && cyc < 20) begin
            @(negedge clock);
            cyc++;
            if (pokeBusy && cyc == 2) begin
                ifc1.enable_alu = 1'b1; ifc1.op = OP_AND; setSel1(SH);
            end
            if (pokeBusy && cyc == 3) begin
                ifc1.enable_alu = 1'b0; setSel1(7'd0);
            end
            if (ifc1.f_we === 1'b1) seen = 1;
        end
        e = sbQ.pop_front();
        checks++;
        if (!seen || cyc != 3) begin
            failures++;
            $display("[TB] FAIL %s latency: f_we at cycle %0d (seen=%0d), required cycle 3", name, cyc, seen);
        end
        checks++;
        if (ifc1.done !== 1'b1 || ifc1.a_we !== e.aWe || ifc1.f_out !== e.fOut ||
            (e.aWe && ifc1.a_out !== e.aOut)) begin
            failures++;
            $display("[TB] FAIL %s result: a_out=%h f_out=%h a_we=%b done=%b, required a_out=%h f_out=%h a_we=%b done=1",
                     name, ifc1.a_out, ifc1.f_out, ifc1.a_we, ifc1.done, e.aOut, e.fOut, e.aWe);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ifc1.enable_alu = 1'b0; ifc1.op = 3'd0; setSel1(7'd0); ifc1.a_in = 8'd0; ifc1.f_in = 8'd0;
        ifc3.enable_alu = 1'b0; ifc3.op = 3'd0; setSel3(7'd0); ifc3.a_in = 8'd0; ifc3.f_in = 8'd0;
        for (int i = 0; i < 8; i++) rfMem[i] = 8'h00;
        repeat (2) @(negedge clock);
        checks++;
        if (ifc1.busy !== 1'b0 || ifc1.done !== 1'b0 || ifc1.err !== 1'b0 || ifc1.rf_re !== 1'b0 ||
            ifc1.a_we !== 1'b0 || ifc1.f_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset strobes: busy=%b done=%b err=%b rf_re=%b a_we=%b f_we=%b, required all 0",
                     ifc1.busy, ifc1.done, ifc1.err, ifc1.rf_re, ifc1.a_we, ifc1.f_we);
        end
        checks++;
        if (ifc1.a_out !== 8'h00 || ifc1.f_out !== 8'h00 || ifc1.rf_addr !== 3'd0) begin
            failures++;
            $display("[TB] FAIL reset data: a_out=%h f_out=%h rf_addr=%0d, required 00 00 0",
                     ifc1.a_out, ifc1.f_out, ifc1.rf_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_arith();
        rfMem[0] = 8'h01; rfMem[3] = 8'h00; rfMem[7] = 8'h42; rfMem[5] = 8'h08;
        applyStimulus("add_b", OP_ADD, SB, 3'd0, 8'h7F, 8'h00, 8'h80, 8'h94, 1'b1, 0);
        applyStimulus("adc_e", OP_ADC, SE, 3'd3, 8'hFF, 8'h01, 8'h00, 8'h51, 1'b1, 0);
        applyStimulus("sub_a", OP_SUB, SA, 3'd7, 8'h42, 8'h00, 8'h00, 8'h42, 1'b1, 0);
        applyStimulus("sbc_b", OP_SBC, SB, 3'd0, 8'h00, 8'h01, 8'hFE, 8'hBB, 1'b1, 0);
        rfMem[3] = 8'h01;
        applyStimulus("sub_e", OP_SUB, SE, 3'd3, 8'h80, 8'h01, 8'h7F, 8'h3E, 1'b1, 0);
        applyStimulus("add_l_nocarry", OP_ADD, SL, 3'd5, 8'h08, 8'h01, 8'h10, 8'h10, 1'b1, 0);
    endtask

    task automatic test_compare();
        rfMem[1] = 8'h20;
        applyStimulus("cp_c", OP_CP, SC, 3'd1, 8'h10, 8'h00, 8'h00, 8'hA3, 1'b0, 0);
    endtask

    task automatic test_logic();
        rfMem[4] = 8'h3C; rfMem[2] = 8'hFF; rfMem[5] = 8'h00;
        applyStimulus("and_h", OP_AND, SH, 3'd4, 8'hF0, 8'h01, 8'h30, 8'h34, 1'b1, 0);
        applyStimulus("xor_d", OP_XOR, SD, 3'd2, 8'h5A, 8'h01, 8'hA5, 8'hA4, 1'b1, 0);
        applyStimulus("or_l",  OP_OR,  SL, 3'd5, 8'h00, 8'h01, 8'h00, 8'h44, 1'b1, 0);
    endtask

    task automatic test_error();
        logic [6:0] pats [2];
        int         bad;
        pats[0] = SB | SC;
        pats[1] = 7'd0;
        for (int p = 0; p < 2; p++) begin
            @(negedge clock);
            ifc1.enable_alu = 1'b1; ifc1.op = OP_ADD; setSel1(pats[p]);
            @(negedge clock);
            ifc1.enable_alu = 1'b0; setSel1(7'd0);
            checks++;
            if (ifc1.err !== 1'b1 || ifc1.busy !== 1'b0 || ifc1.rf_re !== 1'b0) begin
                failures++;
                $display("[TB] FAIL err_pulse pattern %h: err=%b busy=%b rf_re=%b, required 1 0 0",
                         pats[p], ifc1.err, ifc1.busy, ifc1.rf_re);
            end
            bad = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clock);
                if (ifc1.err !== 1'b0 || ifc1.rf_re !== 1'b0 || ifc1.a_we !== 1'b0 ||
                    ifc1.f_we !== 1'b0 || ifc1.busy !== 1'b0) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("[TB] FAIL err_quiet pattern %h: %0d cycles with activity, required 0", pats[p], bad);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int bad;
        rfMem[0] = 8'h01;
        applyStimulus("busy_ignore", OP_ADD, SB, 3'd0, 8'h7F, 8'h00, 8'h80, 8'h94, 1'b1, 1);
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (ifc1.rf_re !== 1'b0 || ifc1.f_we !== 1'b0 || ifc1.busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL busy_ignore queued: %0d active cycles after done, required 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        rfMem[0] = 8'h01; rfMem[4] = 8'h3C;
        applyStimulus("b2b_first",  OP_ADD, SB, 3'd0, 8'h7F, 8'h00, 8'h80, 8'h94, 1'b1, 0);
        applyStimulus("b2b_second", OP_AND, SH, 3'd4, 8'hF0, 8'h00, 8'h30, 8'h34, 1'b1, 0);
    endtask

    task automatic checkOutput();
        @(negedge clock);
        checks++;
        if (ifc1.busy !== 1'b0 || ifc1.a_we !== 1'b0 || ifc1.f_we !== 1'b0 ||
            ifc1.a_out !== 8'h30 || ifc1.f_out !== 8'h34) begin
            failures++;
            $display("[TB] FAIL hold: busy=%b a_we=%b f_we=%b a_out=%h f_out=%h, required 0 0 0 30 34",
                     ifc1.busy, ifc1.a_we, ifc1.f_we, ifc1.a_out, ifc1.f_out);
        end
    endtask

    task automatic test_reset_midop();
        rfMem[0] = 8'h01;
        @(negedge clock);
        ifc1.enable_alu = 1'b1; ifc1.op = OP_ADD; setSel1(SB); ifc1.a_in = 8'h7F; ifc1.f_in = 8'h00;
        @(negedge clock);
        ifc1.enable_alu = 1'b0; setSel1(7'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (ifc1.busy !== 1'b0 || ifc1.a_we !== 1'b0 || ifc1.f_we !== 1'b0 ||
            ifc1.a_out !== 8'h00 || ifc1.f_out !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_midop: busy=%b a_we=%b f_we=%b a_out=%h f_out=%h, required 0 0 0 00 00",
                     ifc1.busy, ifc1.a_we, ifc1.f_we, ifc1.a_out, ifc1.f_out);
        end
        @(negedge clock);
        checks++;
        if (ifc1.f_we !== 1'b0 || ifc1.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_midop_wb: f_we=%b done=%b, required 0 0", ifc1.f_we, ifc1.done);
        end
        reset = 1'b0;
        applyStimulus("after_reset", OP_ADD, SB, 3'd0, 8'h7F, 8'h00, 8'h80, 8'h94, 1'b1, 0);
    endtask

    task automatic test_latency3();
        int cyc;
        bit seen;
        rfMem[0] = 8'h01;
        @(negedge clock);
        ifc3.enable_alu = 1'b1; ifc3.op = OP_ADD; setSel3(SB); ifc3.a_in = 8'h7F; ifc3.f_in = 8'h00;
        @(negedge clock);
        ifc3.enable_alu = 1'b0; setSel3(7'd0); ifc3.a_in = 8'h00;
        checks++;
        if (ifc3.rf_re !== 1'b1 || ifc3.rf_addr !== 3'd0) begin
            failures++;
            $display("[TB] FAIL lat3 read: rf_re=%b rf_addr=%0d, required 1 0", ifc3.rf_re, ifc3.rf_addr);
        end
        cyc  = 1;
        seen = 0;
        while (!seen && cyc < 20) begin
            @(negedge clock);
            cyc++;
            if (ifc3.done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || cyc != 5) begin
            failures++;
            $display("[TB] FAIL lat3 latency: done at cycle %0d (seen=%0d), required cycle 5", cyc, seen);
        end
        checks++;
        if (ifc3.a_out !== 8'h80 || ifc3.f_out !== 8'h94 || ifc3.a_we !== 1'b1 || ifc3.f_we !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lat3 result: a_out=%h f_out=%h a_we=%b f_we=%b, required 80 94 1 1",
                     ifc3.a_out, ifc3.f_out, ifc3.a_we, ifc3.f_we);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_compare();
        test_logic();
        test_error();
        test_busy_ignore();
        test_back_to_back();
        checkOutput();
        test_reset_midop();
        test_latency3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
